// File: rtl/dmem_responder_if.sv
// Bus interface for the data-memory responder.
// Bundles the processor data-memory port and the host RAM access port.
//   Processor side : address_dmem, data, wren -> q_dmem (combinational read)
//   Host side      : proc_hold, host_req, host_we, host_addr, host_wdata
//                    -> host_ack (one-cycle pulse), host_rdata (held)
// master = processor/host side, slave = dmem_responder.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic [31:0]           address_dmem;
    logic [31:0]           data;
    logic                  wren;
    logic [31:0]           q_dmem;
    logic                  proc_hold;
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [31:0]           host_wdata;
    logic                  host_ack;
    logic [31:0]           host_rdata;

    modport master (
        output address_dmem, data, wren,
        output proc_hold, host_req, host_we, host_addr, host_wdata,
        input  q_dmem, host_ack, host_rdata
    );

    modport slave (
        input  address_dmem, data, wren,
        input  proc_hold, host_req, host_we, host_addr, host_wdata,
        output q_dmem, host_ack, host_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus a 4-word MMIO window.
//   clock, reset (async, active-low)
//   bus        : dmem_responder_if.slave (processor + host ports)
//   mbox_pop   : host consumes the mailbox word
//   mbox_valid : mailbox holds an unread word
//   mbox_data  : mailbox word
//   leds       : LED register
// MMIO map (word offsets from MMIO_BASE):
//   +0 CYCLE (RO counter), +1 LEDS, +2 MBOX, +3 STATUS {ovf, valid}
module dmem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_FF00,
    parameter int          LED_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_responder_if.slave      bus,
    input  logic                 mbox_pop,
    output logic                 mbox_valid,
    output logic [31:0]          mbox_data,
    output logic [LED_WIDTH-1:0] leds
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_WAIT} host_state_e;

    logic [31:0] mem [DEPTH];

    host_state_e          state_q, state_d;
    logic [31:0]          cycle_q, cycle_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic                 mbox_valid_q, mbox_valid_d;
    logic [31:0]          mbox_data_q, mbox_data_d;
    logic                 mbox_ovf_q, mbox_ovf_d;
    logic [31:0]          host_rdata_q, host_rdata_d;

    logic                  is_ram, is_mmio;
    logic [31:0]           mmio_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  wr_ok, host_wr, proc_ram_wr;
    logic                  leds_wr, mbox_wr, status_wr;
    logic [31:0]           q_rd;

    // Address decode; RAM wins if a misconfigured window ever overlaps it.
    assign ram_idx  = bus.address_dmem[ADDR_WIDTH-1:0];
    assign is_ram   = (bus.address_dmem >> ADDR_WIDTH) == 32'd0;
    assign mmio_off = bus.address_dmem - MMIO_BASE;
    assign is_mmio  = !is_ram && (mmio_off[31:2] == 30'd0);

    // The host owns the RAM during ACCESS, so processor writes are dropped then.
    assign wr_ok       = bus.wren && (state_q != S_ACCESS);
    assign host_wr     = (state_q == S_ACCESS) && bus.host_we;
    assign proc_ram_wr = wr_ok && is_ram;
    assign leds_wr     = wr_ok && is_mmio && (mmio_off[1:0] == 2'd1);
    assign mbox_wr     = wr_ok && is_mmio && (mmio_off[1:0] == 2'd2);
    assign status_wr   = wr_ok && is_mmio && (mmio_off[1:0] == 2'd3);

    always_comb begin
        q_rd = 32'd0;
        if (is_ram) begin
            q_rd = mem[ram_idx];
        end else if (is_mmio) begin
            case (mmio_off[1:0])
                2'd0:    q_rd = cycle_q;
                2'd1:    q_rd = 32'(leds_q);
                2'd2:    q_rd = mbox_data_q;
                default: q_rd = {30'd0, mbox_ovf_q, mbox_valid_q};
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q + 32'd1;
        leds_d       = leds_q;
        mbox_valid_d = mbox_valid_q;
        mbox_data_d  = mbox_data_q;
        mbox_ovf_d   = mbox_ovf_q;
        host_rdata_d = host_rdata_q;

        if (leds_wr) begin
            leds_d = bus.data[LED_WIDTH-1:0];
        end

        // A same-cycle pop frees the slot, so the write is accepted then.
        if (mbox_wr) begin
            if (mbox_valid_q && !mbox_pop) begin
                mbox_ovf_d = 1'b1;
            end else begin
                mbox_data_d  = bus.data;
                mbox_valid_d = 1'b1;
            end
        end else if (mbox_pop) begin
            mbox_valid_d = 1'b0;
        end

        if (status_wr) begin
            mbox_ovf_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.host_req && bus.proc_hold) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (!bus.host_we) host_rdata_d = mem[bus.host_addr];
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = bus.host_req ? S_WAIT : S_IDLE;
            end
            default: begin
                if (!bus.host_req) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cycle_q      <= 32'd0;
            leds_q       <= '0;
            mbox_valid_q <= 1'b0;
            mbox_data_q  <= 32'd0;
            mbox_ovf_q   <= 1'b0;
            host_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            leds_q       <= leds_d;
            mbox_valid_q <= mbox_valid_d;
            mbox_data_q  <= mbox_data_d;
            mbox_ovf_q   <= mbox_ovf_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (host_wr) begin
            mem[bus.host_addr] <= bus.host_wdata;
        end else if (proc_ram_wr) begin
            mem[ram_idx] <= bus.data;
        end
    end

    assign bus.q_dmem     = q_rd;
    assign bus.host_ack   = (state_q == S_ACK);
    assign bus.host_rdata = host_rdata_q;
    assign mbox_valid     = mbox_valid_q;
    assign mbox_data      = mbox_data_q;
    assign leds           = leds_q;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int          AW = 12;
    localparam logic [31:0] MB = 32'h0000_FF00;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mbox_pop;
    logic        mbox_valid;
    logic [31:0] mbox_data;
    logic [7:0]  leds;

    dmem_responder_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_responder #(
        .ADDR_WIDTH(AW),
        .MMIO_BASE (MB),
        .LED_WIDTH (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .mbox_pop  (mbox_pop),
        .mbox_valid(mbox_valid),
        .mbox_data (mbox_data),
        .leds      (leds)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic        pop;
        logic        chk_q;
        logic [31:0] exp_q;
        logic        exp_mv;
        logic [31:0] exp_md;
        logic [7:0]  exp_leds;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic wren, input logic pop, input logic chk_q,
                                input logic [31:0] exp_q, input logic exp_mv,
                                input logic [31:0] exp_md, input logic [7:0] exp_leds);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.wren = wren; v.pop = pop; v.chk_q = chk_q;
        v.exp_q = exp_q; v.exp_mv = exp_mv; v.exp_md = exp_md; v.exp_leds = exp_leds;
        return v;
    endfunction

    vec_t vecs[21];
    logic seen_ack;

    task automatic proc_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.address_dmem = a; bus.data = d; bus.wren = 1'b1;
        @(negedge clock);
        bus.wren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address_dmem = MB; bus.data = 32'd0; bus.wren = 1'b0;
        bus.proc_hold = 1'b0; bus.host_req = 1'b0; bus.host_we = 1'b0;
        bus.host_addr = '0; bus.host_wdata = 32'd0; mbox_pop = 1'b0;

        vecs[0]  = mk(32'd5,        32'h1111_1111, 1, 0, 0, 32'h0,         0, 32'd0,  8'h00);
        vecs[1]  = mk(32'd5,        32'hDEAD_BEEF, 1, 0, 1, 32'h1111_1111, 0, 32'd0,  8'h00);
        vecs[2]  = mk(32'd5,        32'h0,         0, 0, 1, 32'hDEAD_BEEF, 0, 32'd0,  8'h00);
        vecs[3]  = mk(32'h0001_0000, 32'h55,       1, 0, 1, 32'h0,         0, 32'd0,  8'h00);
        vecs[4]  = mk(32'h0001_0000, 32'h0,        0, 0, 1, 32'h0,         0, 32'd0,  8'h00);
        vecs[5]  = mk(32'h0000_0FFF, 32'hA5A5_A5A5, 1, 0, 0, 32'h0,        0, 32'd0,  8'h00);
        vecs[6]  = mk(32'h0000_0FFF, 32'h0,        0, 0, 1, 32'hA5A5_A5A5, 0, 32'd0,  8'h00);
        vecs[7]  = mk(32'h0000_1000, 32'h0,        0, 0, 1, 32'h0,         0, 32'd0,  8'h00);
        vecs[8]  = mk(MB + 32'd1,   32'h1FF,       1, 0, 1, 32'h0,         0, 32'd0,  8'hFF);
        vecs[9]  = mk(MB + 32'd1,   32'h0,         0, 0, 1, 32'h0000_00FF, 0, 32'd0,  8'hFF);
        vecs[10] = mk(MB + 32'd2,   32'd7,         1, 0, 1, 32'h0,         1, 32'd7,  8'hFF);
        vecs[11] = mk(MB + 32'd2,   32'd9,         1, 0, 1, 32'd7,         1, 32'd7,  8'hFF);
        vecs[12] = mk(MB + 32'd3,   32'h0,         0, 0, 1, 32'd3,         1, 32'd7,  8'hFF);
        vecs[13] = mk(MB + 32'd2,   32'd11,        1, 1, 1, 32'd7,         1, 32'd11, 8'hFF);
        vecs[14] = mk(MB + 32'd3,   32'h0,         0, 0, 1, 32'd3,         1, 32'd11, 8'hFF);
        vecs[15] = mk(MB + 32'd3,   32'h0,         1, 0, 1, 32'd3,         1, 32'd11, 8'hFF);
        vecs[16] = mk(MB + 32'd3,   32'h0,         0, 0, 1, 32'd1,         1, 32'd11, 8'hFF);
        vecs[17] = mk(32'd5,        32'h0,         0, 1, 1, 32'hDEAD_BEEF, 0, 32'd11, 8'hFF);
        vecs[18] = mk(MB + 32'd3,   32'h0,         0, 1, 1, 32'd0,         0, 32'd11, 8'hFF);
        vecs[19] = mk(MB + 32'd4,   32'h0,         0, 0, 1, 32'd0,         0, 32'd11, 8'hFF);
        vecs[20] = mk(MB - 32'd1,   32'h0,         0, 0, 1, 32'd0,         0, 32'd11, 8'hFF);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("rst q_dmem cycle", bus.q_dmem, 32'd0);
        check("rst host_ack", 32'(bus.host_ack), 32'd0);
        check("rst host_rdata", bus.host_rdata, 32'd0);
        check("rst mbox_valid", 32'(mbox_valid), 32'd0);
        check("rst mbox_data", mbox_data, 32'd0);
        check("rst leds", 32'(leds), 32'd0);

        // Cycle counter
        @(negedge clock);
        reset = 1'b1;
        #1 check("cycle at 0", bus.q_dmem, 32'd0);
        repeat (10) @(posedge clock);
        @(negedge clock); #1;
        check("cycle at 10", bus.q_dmem, 32'd10);

        @(negedge clock);
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1 release dut.cycle_q;
        #1 check("cycle forced", bus.q_dmem, 32'hFFFF_FFFE);
        @(posedge clock); #1 check("cycle max", bus.q_dmem, 32'hFFFF_FFFF);
        @(posedge clock); #1 check("cycle wrap", bus.q_dmem, 32'd0);
        bus.data = 32'h0000_AAAA; bus.wren = 1'b1;
        @(posedge clock); #1 check("cycle write ignored", bus.q_dmem, 32'd1);
        bus.wren = 1'b0;

        // Table-driven processor vectors
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            bus.address_dmem = vecs[i].addr;
            bus.data         = vecs[i].wdata;
            bus.wren         = vecs[i].wren;
            mbox_pop         = vecs[i].pop;
            #1;
            if (vecs[i].chk_q) check($sformatf("vec%0d q_dmem", i), bus.q_dmem, vecs[i].exp_q);
            @(posedge clock); #1;
            check($sformatf("vec%0d mbox_valid", i), 32'(mbox_valid), 32'(vecs[i].exp_mv));
            check($sformatf("vec%0d mbox_data", i), mbox_data, vecs[i].exp_md);
            check($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
        end
        @(negedge clock);
        bus.wren = 1'b0; mbox_pop = 1'b0;

        // Host write blocked until proc_hold; processor write dropped in ACCESS
        proc_write(32'h200, 32'h77);
        bus.host_we = 1'b1; bus.host_addr = 12'h123; bus.host_wdata = 32'hCAFE_F00D;
        bus.host_req = 1'b1; bus.proc_hold = 1'b0;
        seen_ack = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus.host_ack) seen_ack = 1'b1;
        end
        check("no ack without hold", 32'(seen_ack), 32'd0);
        bus.proc_hold = 1'b1;
        @(negedge clock);
        check("ack early", 32'(bus.host_ack), 32'd0);
        bus.address_dmem = 32'h200; bus.data = 32'h99; bus.wren = 1'b1;
        @(negedge clock);
        check("ack pulse", 32'(bus.host_ack), 32'd1);
        bus.wren = 1'b0;
        seen_ack = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (bus.host_ack) seen_ack = 1'b1;
        end
        check("single ack held req", 32'(seen_ack), 32'd0);
        bus.host_req = 1'b0;
        @(negedge clock);
        bus.address_dmem = 32'h123;
        #1 check("host write visible", bus.q_dmem, 32'hCAFE_F00D);
        bus.address_dmem = 32'h200;
        #1 check("proc write in ACCESS", bus.q_dmem, 32'h77);

        // Host read; hold drops during ACCESS but access completes
        @(negedge clock);
        bus.host_we = 1'b0; bus.host_req = 1'b1;
        @(negedge clock);
        bus.proc_hold = 1'b0;
        check("read ack early", 32'(bus.host_ack), 32'd0);
        @(negedge clock);
        check("read ack", 32'(bus.host_ack), 32'd1);
        check("read data", bus.host_rdata, 32'hCAFE_F00D);
        bus.host_req = 1'b0;
        repeat (2) @(negedge clock);
        check("read data held", bus.host_rdata, 32'hCAFE_F00D);
        check("ack low after", 32'(bus.host_ack), 32'd0);

        // Reset during ACCESS
        proc_write(32'd100, 32'h1234);
        proc_write(MB + 32'd2, 32'h42);
        check("mbox before rst", 32'(mbox_valid), 32'd1);
        bus.proc_hold = 1'b1; bus.host_req = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 12'd100; bus.host_wdata = 32'h0000_0BAD;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst leds", 32'(leds), 32'd0);
        check("rst mbox_valid", 32'(mbox_valid), 32'd0);
        seen_ack = bus.host_ack;
        bus.host_req = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus.host_ack) seen_ack = 1'b1;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.host_ack) seen_ack = 1'b1;
        end
        check("no ack after abort", 32'(seen_ack), 32'd0);
        bus.address_dmem = 32'd5;
        #1 check("ram kept addr5", bus.q_dmem, 32'hDEAD_BEEF);
        bus.address_dmem = 32'd100;
        #1 check("aborted write", bus.q_dmem, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
